// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB-first, one bit per clock.
// Results are captured on the final RUN edge and held until the next completion or reset.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             mode_q, carry_q;
  logic [CW-1:0]    cnt;

  logic             accept_c, last_c;
  logic             b_bit_c, sum_c, carry_c;
  logic [WIDTH-1:0] res_shift_c;

  // Full-adder cell; B is inverted in subtract mode, with the carry preloaded to 1
  always_comb begin
    b_bit_c     = b_sh[0] ^ mode_q;
    sum_c       = a_sh[0] ^ b_bit_c ^ carry_q;
    carry_c     = (a_sh[0] & b_bit_c) | (carry_q & (a_sh[0] ^ b_bit_c));
    res_shift_c = res_sh >> 1;
    res_shift_c[WIDTH-1] = sum_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    last_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c   = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last_c     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        // Back-to-back start skips IDLE entirely
        if (start) begin
          accept_c   = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      busy <= (next_state == RUN);
      done <= (next_state == DONE);
      if (accept_c) begin
        a_sh    <= a;
        b_sh    <= b;
        mode_q  <= mode;
        carry_q <= mode;
        res_sh  <= '0;
        cnt     <= '0;
      end else if (state == RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        res_sh  <= res_shift_c;
        carry_q <= carry_c;
        cnt     <= cnt + CW'(1);
        if (last_c) begin
          result <= res_shift_c;
          cout   <= carry_c;
          ovf    <= carry_q ^ carry_c;
        end
      end
    end
  end

endmodule
